// File: rtl/reg_arb_pkg.sv
// reg_arb_pkg: FSM state encoding, requester count and default data width for reg_share_arb
package reg_arb_pkg;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] GRANT     = 2'd1;
  localparam logic [1:0] ACK       = 2'd2;
  localparam int         NREQ      = 2;
  localparam int         DEF_WIDTH = 8;
endpackage

// File: rtl/shared_reg.sv
// shared_reg: WIDTH-bit storage register with load enable and asynchronous active-low clear
import reg_arb_pkg::*;
module shared_reg #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  // load new contents when enabled, clear on reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '0;
    else if (ld) q <= d;
endmodule

// File: rtl/reg_share_arb.sv
// reg_share_arb: round-robin arbiter giving two requesters read/write access to one shared register
// Optional feature: define REG_ARB_LOCK_EN to let a locked winner re-enter GRANT straight from ACK.
import reg_arb_pkg::*;
module reg_share_arb #(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NREQ-1:0]  req,
  input  logic [NREQ-1:0]  wr,
  input  logic [WIDTH-1:0] wdata0,
  input  logic [WIDTH-1:0] wdata1,
  input  logic [NREQ-1:0]  lock,
  output logic [NREQ-1:0]  gnt,
  output logic [NREQ-1:0]  ack,
  output logic [WIDTH-1:0] rdata,
  output logic [WIDTH-1:0] q,
  output logic             busy
);
  logic [1:0]       state;
  logic             rdy, ptr, win, win_n, wr_l, hold;
  logic [WIDTH-1:0] wd_l;
  // a lone request wins outright; a tie goes to the requester the pointer favours
  always_comb win_n = (req == 2'b11) ? ptr : req[1];
`ifdef REG_ARB_LOCK_EN
  // the current winner keeps the register while it still requests and locks
  always_comb hold = lock[win] & req[win];
`else
  logic unused_lock;
  always_comb unused_lock = ^lock;
  always_comb hold = 1'b0;
`endif
  always_comb busy = (state != IDLE);
  // arbitration FSM: rdy holds off the first grant for one edge after reset release
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      gnt   <= '0;
      ack   <= '0;
      rdata <= '0;
      rdy   <= 1'b0;
      ptr   <= 1'b0;
      win   <= 1'b0;
      wr_l  <= 1'b0;
      wd_l  <= '0;
    end else begin
      rdy <= 1'b1;
      case (state)
        IDLE: if (rdy && req != '0) begin
          state <= GRANT;
          gnt   <= win_n ? 2'b10 : 2'b01;
          win   <= win_n;
          ptr   <= ~win_n;
          wr_l  <= wr[win_n];
          wd_l  <= win_n ? wdata1 : wdata0;
        end
        GRANT: begin
          state <= ACK;
          gnt   <= '0;
          ack   <= gnt;
          if (!wr_l) rdata <= q;
        end
        ACK: begin
          ack <= '0;
          if (hold) begin
            state <= GRANT;
            gnt   <= ack;
            wr_l  <= wr[win];
            wd_l  <= win ? wdata1 : wdata0;
          end else state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  shared_reg #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .rst_n(rst_n),
    .ld   (state == GRANT && wr_l),
    .d    (wd_l),
    .q    (q)
  );
endmodule

// File: tb/tb_reg_share_arb.sv
// tb_reg_share_arb: directed plus random checks of reg_share_arb against a transaction-level reference model
module tb_reg_share_arb;
`ifdef REG_ARB_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif
  logic       clk = 1'b0, rst_n = 1'b0;
  logic [1:0] req = '0, wr = '0, lock = '0, gnt, ack;
  logic [7:0] wdata0 = '0, wdata1 = '0, rdata, q;
  logic       busy;
  int         n_chk = 0, n_fail = 0;
  // reference model: phase 0 = waiting, 1 = granted, 2 = acknowledging
  int         phase, owner, fav;
  bit         ready, acc_wr;
  logic [7:0] acc_data, m_q, m_rdata;
  logic [1:0] ack_log[$];

  reg_share_arb #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .wdata0(wdata0), .wdata1(wdata1),
    .lock(lock), .gnt(gnt), .ack(ack), .rdata(rdata), .q(q), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare(input string tag);
    chk({tag, ".gnt"}, 32'(gnt), (phase == 1) ? 32'(1 << owner) : 32'd0);
    chk({tag, ".ack"}, 32'(ack), (phase == 2) ? 32'(1 << owner) : 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'(phase != 0));
    chk({tag, ".q"}, 32'(q), 32'(m_q));
    chk({tag, ".rdata"}, 32'(rdata), 32'(m_rdata));
  endtask

  task automatic take(input int who);
    owner    = who;
    acc_wr   = wr[who];
    acc_data = who ? wdata1 : wdata0;
    phase    = 1;
  endtask

  // advance the model by one clock using the inputs currently applied, then check the DUT
  task automatic tick(input string tag);
    case (phase)
      0: if (ready && req != 2'b00) begin
        take((req == 2'b11) ? fav : (req == 2'b10 ? 1 : 0));
        fav = 1 - owner;
      end
      1: begin
        if (acc_wr) m_q = acc_data;
        else m_rdata = m_q;
        phase = 2;
      end
      default: if (LOCK_EN && lock[owner] && req[owner]) take(owner);
               else phase = 0;
    endcase
    ready = 1'b1;
    @(posedge clk);
    #1;
    if (ack != 2'b00) ack_log.push_back(ack);
    compare(tag);
  endtask

  task automatic model_reset();
    phase = 0; owner = 0; fav = 0; ready = 1'b0;
    m_q = '0; m_rdata = '0;
  endtask

  // pulse reset between edges and check the asynchronous clear before releasing it
  task automatic pulse_reset(input string tag);
    rst_n = 1'b0;
    model_reset();
    #1;
    compare(tag);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    // reset with no requests: everything idle and cleared
    #2;
    compare("rst");
    @(negedge clk);
    rst_n = 1'b1;
    req = 2'b01; wr = 2'b01; wdata0 = 8'hA5;
    tick("w0_holdoff");
    chk("w0_holdoff_gnt", 32'(gnt), 32'd0);
    tick("w0_gnt");
    chk("w0_gnt_dir", 32'(gnt), 32'h1);
    req = 2'b00;
    tick("w0_ack");
    chk("w0_ack_dir", 32'(ack), 32'h1);
    chk("w0_q_dir", 32'(q), 32'hA5);
    tick("w0_idle");
    // requester 1 writes 3C then reads it back
    req = 2'b10; wr = 2'b10; wdata1 = 8'h3C;
    repeat (3) tick("w1");
    wr = 2'b00;
    repeat (2) tick("r1");
    req = 2'b00;
    tick("r1_ack");
    chk("r1_rdata_dir", 32'(rdata), 32'h3C);
    chk("r1_q_dir", 32'(q), 32'h3C);
    tick("r1_idle");
    // simultaneous requests right after reset: 0 first, then 1
    pulse_reset("rst2");
    req = 2'b11; wr = 2'b11; wdata0 = 8'h11; wdata1 = 8'h22;
    ack_log.delete();
    repeat (7) tick("tie");
    chk("tie_nacks", 32'(ack_log.size()), 32'd2);
    if (ack_log.size() >= 2) begin
      chk("tie_first", 32'(ack_log[0]), 32'h1);
      chk("tie_second", 32'(ack_log[1]), 32'h2);
    end
    req = 2'b00;
    repeat (3) tick("tie_drain");
    // dropping req after the grant must not cancel the write
    req = 2'b01; wr = 2'b01; wdata0 = 8'h77;
    tick("drop_gnt");
    req = 2'b00; wdata0 = 8'h00;
    tick("drop_ack");
    chk("drop_q_dir", 32'(q), 32'h77);
    tick("drop_idle");
    // reset landing in GRANT throws away the FF write
    req = 2'b01; wr = 2'b01; wdata0 = 8'hFF;
    tick("rstg_gnt");
    pulse_reset("rstg");
    chk("rstg_q_dir", 32'(q), 32'h0);
    req = 2'b00;
    repeat (2) tick("rstg_after");
    // lock held by requester 0 against a competing requester 1
    req = 2'b11; wr = 2'b00; lock = 2'b01;
    ack_log.delete();
    repeat (10) tick("lock");
    if (LOCK_EN) chk("lock_only0", 32'(ack_log.size()), 32'(ack_log.find_first_index(x) with (x == 2'b10).size() == 0 ? ack_log.size() : 0));
    else chk("nolock_alt", 32'(ack_log[0] != ack_log[1]), 32'd1);
    lock = 2'b00;
    repeat (6) tick("unlock");
    req = 2'b00;
    repeat (3) tick("lock_drain");
    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      req = 2'($urandom_range(0, 3));
      wr = 2'($urandom_range(0, 3));
      lock = 2'($urandom_range(0, 3));
      wdata0 = 8'($urandom);
      wdata1 = 8'($urandom);
      if ($urandom_range(0, 59) == 0) pulse_reset("rnd_rst");
      tick("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/reg_share_arb.md
REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width of the shared storage register.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port req  input  2  access request per requester (bit i = requester i).
REQ-005 SHALL have port wr  input  2  per requester: 1 = write, 0 = read; sampled with req.
REQ-006 SHALL have ports wdata0 and wdata1, each input WIDTH, write data of requester 0 and 1.
REQ-007 SHALL have port lock  input  2  per-requester hold request; used only when REG_ARB_LOCK_EN is defined.
REQ-008 SHALL have port gnt  output  2  one-hot grant, registered.
REQ-009 SHALL have port ack  output  2  one-hot completion pulse, registered.
REQ-010 SHALL have port rdata  output  WIDTH  read data, valid while ack is high.
REQ-011 SHALL have port q  output  WIDTH  current shared register contents.
REQ-012 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-013 SHALL implement FSM states IDLE, GRANT, ACK.
REQ-014 IDLE: if req != 0, SHALL select a winner, assert gnt[winner] and enter GRANT on the next edge; otherwise stay in IDLE.
REQ-015 Arbitration SHALL be round-robin: a single request wins; on simultaneous requests the requester whose pointer bit is set wins; the pointer SHALL move to the other requester on every grant.
REQ-016 GRANT SHALL last exactly one cycle; on its closing edge a write SHALL load the winner's wdata into the register, and a read SHALL capture q into rdata.
REQ-017 ACK SHALL last exactly one cycle with ack[winner]=1 and gnt=0, then the FSM SHALL return to IDLE.
REQ-018 Latency SHALL be: req high in IDLE -> gnt next cycle -> ack the cycle after; at most one access per 3 cycles.
REQ-019 req, wr and wdata SHALL be sampled at the IDLE->GRANT edge; a req drop during GRANT or ACK SHALL NOT cancel the committed access.
REQ-020 A req still high during ACK SHALL be treated as a new request in the following IDLE cycle.
REQ-021 gnt and ack SHALL never have more than one bit set and SHALL never be high in the same cycle.
REQ-022 rdata SHALL hold its last value outside ACK; writes SHALL leave rdata unchanged.

Reset
REQ-023 rst_n low SHALL immediately force state=IDLE, gnt=0, ack=0, rdata=0, q=0, busy=0, with the pointer favoring requester 0.
REQ-024 Reset asserted during GRANT SHALL discard the in-flight access; the register SHALL read 0 after reset.
REQ-025 After rst_n deassertion the first grant SHALL be issued no earlier than the second rising edge.

Configuration
REQ-026 With REG_ARB_LOCK_EN defined, if lock[winner] and req[winner] are both high during ACK, the FSM SHALL go directly to GRANT for the same winner, skipping IDLE and leaving the pointer unchanged.
REQ-027 Without REG_ARB_LOCK_EN, the lock port SHALL be present but ignored, and ACK SHALL always return to IDLE.

Structure
REQ-028 Package reg_arb_pkg SHALL hold the state encoding constants (IDLE, GRANT, ACK), the requester count NREQ=2, and the default WIDTH.
REQ-029 Storage SHALL be a sub-module shared_reg: a WIDTH-bit register with load enable and asynchronous active-low clear, instantiated once.

Verification
REQ-030 Reset with req=00: q=0, gnt=00, busy=0; then req=01, wr=01, wdata0=8'hA5 -> gnt=01 next cycle, ack=01 the cycle after, q=8'hA5.
REQ-031 Simultaneous req=11 right after reset -> requester 0 is granted first, requester 1 second; ack order is 01 then 10.
REQ-032 Read: q=8'h3C, req=10, wr=00 -> ack=10 with rdata=8'h3C; q stays unchanged.
REQ-033 Drop req one cycle after gnt rises -> ack is still produced and a write of 8'h77 still lands in q.
REQ-034 Assert rst_n=0 during GRANT of a write of 8'hFF -> gnt=00 and ack=00 immediately, and q=0.
REQ-035 With REG_ARB_LOCK_EN defined, req=11 and lock=01 held -> requester 0 receives back-to-back grants every 2 cycles and requester 1 waits until lock[0] drops; without the macro, grants alternate.
